seq_frame_tx: RTL

Serial frame transmitter that feeds the team's "101" sequence detector. It accepts a parallel word over a valid/ready handshake, then emits it one bit per clock, MSB first, behind a fixed "101" preamble. Idle zeros separate consecutive frames. It sits on the transmit side of the single-wire serial link, driving the detector's `x_in`.

---
 rtl/seq_frame_tx_if.sv | 33 +++
 rtl/seq_frame_tx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seq_frame_tx_if.sv
// Handshake and serial-output bundle for seq_frame_tx.
// The word source is the master; the transmitter itself sits on the slave modport.
interface seq_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              x_out;
    logic              x_valid;
    logic              frame_done;
    logic              busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  x_out,
        input  x_valid,
        input  frame_done,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output x_out,
        output x_valid,
        output frame_done,
        output busy
    );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: "101" preamble, DATA_W payload bits MSB first, then GAP idle zeros.
// All serial outputs are registered; in_ready/busy decode directly from the state register.
module seq_frame_tx #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic          clk,
    input  logic          reset,
    seq_frame_tx_if.slave bus
);
    localparam int CNT_MAX = (DATA_W > GAP) ? ((DATA_W > 3) ? DATA_W : 3)
                                            : ((GAP > 3) ? GAP : 3);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(2);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
    // Guarded so a GAP=0 build never evaluates a negative load value.
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             state_reg,      state_next;
    logic [CNT_W-1:0]   cnt_reg,        cnt_next;
    logic [DATA_W-1:0]  shift_reg,      shift_next;
    logic               x_out_reg,      x_out_next;
    logic               x_valid_reg,    x_valid_next;
    logic               frame_done_reg, frame_done_next;

    logic [DATA_W-1:0]  shift_left;
    logic               cnt_zero;

    assign cnt_zero = (cnt_reg == '0);

    assign shift_left[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < DATA_W; gi++) begin : g_shift
            assign shift_left[gi] = shift_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            shift_reg      <= '0;
            x_out_reg      <= 1'b0;
            x_valid_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shift_reg      <= shift_next;
            x_out_reg      <= x_out_next;
            x_valid_reg    <= x_valid_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_next = S_PRE;
                    cnt_next   = PRE_LOAD;
                    shift_next = bus.in_data;
                end
            end
            S_PRE: begin
                if (cnt_zero) begin
                    state_next = S_DATA;
                    cnt_next   = DATA_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            S_DATA: begin
                // The MSB on entry is shown unshifted; each DATA cycle exposes the next bit.
                shift_next = shift_left;
                if (cnt_zero) begin
                    if (GAP > 0) begin
                        state_next = S_GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next-state values so they land in flops aligned with the state.
    always_comb begin
        x_out_next      = 1'b0;
        x_valid_next    = 1'b0;
        frame_done_next = 1'b0;

        unique case (state_next)
            S_PRE: begin
                x_valid_next = 1'b1;
                x_out_next   = (cnt_next != CNT_ONE);
            end
            S_DATA: begin
                x_valid_next    = 1'b1;
                x_out_next      = shift_next[DATA_W-1];
                frame_done_next = (cnt_next == '0);
            end
            default: begin
                x_out_next      = 1'b0;
                x_valid_next    = 1'b0;
                frame_done_next = 1'b0;
            end
        endcase
    end

    assign bus.in_ready   = (state_reg == S_IDLE);
    assign bus.busy       = (state_reg != S_IDLE);
    assign bus.x_out      = x_out_reg;
    assign bus.x_valid    = x_valid_reg;
    assign bus.frame_done = frame_done_reg;

endmodule
